// File: rtl/in_iface_pkg.sv
// rtl/in_iface_pkg.sv - shared I/O package for the in_iface input port block
// Holds register offsets, STATUS bit positions, producer FSM encoding and
// the buffer depth selected by the IN_IFACE_FIFO2_EN build macro.
package in_iface_pkg;

   localparam logic [1:0] STATUS_OFS = 2'd0;
   localparam logic [1:0] RBR_OFS    = 2'd1;
   localparam logic [1:0] CTRL_OFS   = 2'd2;

   localparam int FI_BIT = 0;

`ifdef IN_IFACE_FIFO2_EN
   localparam int BUF_DEPTH = 2;
`else
   localparam int BUF_DEPTH = 1;
`endif

   typedef enum logic [1:0] {
      P_IDLE      = 2'd0,
      P_WAIT_HIGH = 2'd1,
      P_FULL      = 2'd2
   } p_state_t;

endpackage

// File: rtl/in_iface_buf.sv
// rtl/in_iface_buf.sv - receive buffer storage and occupancy count
// Ports: clock, reset_ (async active-low), push/din (capture a byte),
//        pop (drop the head), flush (empty the buffer), head (oldest byte),
//        count (number of bytes held, 0..DEPTH).
module in_iface_buf
   import in_iface_pkg::*;
#(
   parameter int DEPTH = BUF_DEPTH
) (
   input  logic       clock,
   input  logic       reset_,
   input  logic       push,
   input  logic       pop,
   input  logic       flush,
   input  logic [7:0] din,
   output logic [7:0] head,
   output logic [1:0] count
);

   localparam logic [1:0] DEPTH_C = 2'(DEPTH);

   // Shift-style storage: mem[0] is always the head entry.
   logic [7:0] mem [0:1];
   logic [1:0] cnt_q;

   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         cnt_q  <= 2'd0;
         mem[0] <= 8'h00;
         mem[1] <= 8'h00;
      end else if (flush) begin
         cnt_q <= 2'd0;
      end else if (push && pop && (cnt_q != 2'd0)) begin
         // Simultaneous capture and pop: occupancy is unchanged.
         if (cnt_q == 2'd2) begin
            mem[0] <= mem[1];
            mem[1] <= din;
         end else begin
            mem[0] <= din;
         end
      end else if (pop && (cnt_q != 2'd0)) begin
         mem[0] <= mem[1];
         cnt_q  <= cnt_q - 2'd1;
      end else if (push && (cnt_q < DEPTH_C)) begin
         mem[cnt_q[0]] <= din;
         cnt_q         <= cnt_q + 2'd1;
      end
   end

   assign head  = mem[0];
   assign count = cnt_q;

endmodule

// File: rtl/in_iface.sv
// rtl/in_iface.sv - byte input port: producer handshake, RBR buffer, bus registers
// Ports: clock, reset_ (async active-low), s_ (chip select), addr (register
//        offset), ior_/iow_ (bus strobes), data (8-bit bidirectional bus),
//        dav_ (producer data valid), rfd (ready for data), byte_in (producer byte).
// Build macro: IN_IFACE_FIFO2_EN selects a 2-entry buffer instead of 1 entry.
module in_iface
   import in_iface_pkg::*;
(
   input  logic       clock,
   input  logic       reset_,
   input  logic       s_,
   input  logic [1:0] addr,
   input  logic       ior_,
   input  logic       iow_,
   inout  wire  [7:0] data,
   input  logic       dav_,
   output logic       rfd,
   input  logic [7:0] byte_in
);

   p_state_t   state_q, state_d;
   logic       ior_q, iow_q;
   logic [7:0] rbr_q;

   logic       push, pop, flush, fi, full;
   logic [7:0] head;
   logic [1:0] count;

   logic       eor_rbr;
   logic       rd_en;
   logic [7:0] rd_data;

   in_iface_buf #(.DEPTH(BUF_DEPTH)) u_buf (
      .clock (clock),
      .reset_(reset_),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .din   (byte_in),
      .head  (head),
      .count (count)
   );

   assign fi   = (count != 2'd0);
   assign full = (count == 2'(BUF_DEPTH));

   // Bus strobe edge detection against the previous cycle's strobe level.
   assign eor_rbr = !ior_q && ior_ && !s_ && (addr == RBR_OFS);
   assign flush   = !iow_q && iow_ && !s_ && (addr == CTRL_OFS) && data[0];
   // A read of an empty RBR only replays the last value; it pops nothing.
   assign pop     = eor_rbr && fi && !flush;

   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         state_q <= P_IDLE;
         ior_q   <= 1'b1;
         iow_q   <= 1'b1;
         rbr_q   <= 8'h00;
      end else begin
         state_q <= state_d;
         ior_q   <= ior_;
         iow_q   <= iow_;
         if (pop) begin
            rbr_q <= head;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      push    = 1'b0;
      case (state_q)
         P_IDLE: begin
            if (!dav_) begin
               push    = 1'b1;
               state_d = P_WAIT_HIGH;
            end
         end
         P_WAIT_HIGH: begin
            if (dav_) begin
               state_d = full ? P_FULL : P_IDLE;
            end
         end
         P_FULL: begin
            if (!full) begin
               state_d = P_IDLE;
            end
         end
         default: state_d = P_IDLE;
      endcase
      // The producer must still release dav_ before a new capture, so a
      // flush never cuts short the wait for the high level.
      if (flush && (state_q != P_WAIT_HIGH)) begin
         state_d = P_IDLE;
      end
   end

   assign rfd = (state_q == P_IDLE);

   always_comb begin
      rd_data = 8'h00;
      rd_en   = !s_ && !ior_ && iow_;
      case (addr)
         STATUS_OFS: rd_data[FI_BIT] = fi;
         // Empty buffer: show the last value handed out.
         RBR_OFS:    rd_data = fi ? head : rbr_q;
         default:    rd_en = 1'b0;
      endcase
   end

   assign data = rd_en ? rd_data : 8'hzz;

endmodule

// File: doc/in_iface.md
IN_IFACE -- requirements
Module: in_iface

Interface
REQ-001 SHALL have port clock, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset_, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port s_, input, 1 bit: chip select, active-low, from the address-decode mask (0xAAA0..0xAAA3).
REQ-004 SHALL have port addr, input, 2 bits: register offset (0 STATUS, 1 RBR, 2 CTRL, 3 not decoded by this block).
REQ-005 SHALL have ports ior_ and iow_, input, 1 bit each: bus read and write strobes, active-low.
REQ-006 SHALL have port data, inout, 8 bits: bus data; high-Z unless driven per REQ-010.
REQ-007 SHALL have port dav_, input, 1 bit: producer data-valid, active-low.
REQ-008 SHALL have port rfd, output, 1 bit: ready-for-data to producer, active-high.
REQ-009 SHALL have port byte_in, input, 8 bits: producer data, valid while dav_=0.

Function
REQ-010 SHALL drive data combinationally when s_=0, ior_=0, iow_=1: addr=0 -> {7'b0, FI}, addr=1 -> RBR head; otherwise high-Z.
REQ-011 SHALL run producer FSM P_IDLE, P_WAIT_HIGH, P_FULL. P_IDLE: rfd=1; when dav_=0, capture byte_in into buffer, set FI, go to P_WAIT_HIGH.
REQ-012 SHALL, in P_WAIT_HIGH, hold rfd=0 and, on dav_=1, go to P_FULL if buffer full, else P_IDLE.
REQ-013 SHALL, in P_FULL, hold rfd=0 and go to P_IDLE in the cycle after the buffer stops being full.
REQ-014 SHALL register ior_ each cycle and detect end-of-read as previous ior_=0 and current ior_=1, qualified by s_=0 and addr=1 sampled in the same cycle.
REQ-015 SHALL, on end-of-read of RBR with FI=1, pop the head entry; FI clears when the buffer becomes empty.
REQ-016 SHALL make end-of-read of RBR with FI=0 return the last RBR value, with no state change.
REQ-017 SHALL make end-of-read of STATUS have no side effect.
REQ-018 SHALL, on iow_ rising edge with s_=0, addr=2 and data[0]=1, flush: buffer emptied, FI=0, FSM to P_IDLE if not in P_WAIT_HIGH.
REQ-019 SHALL, when a capture and a pop occur in the same cycle, apply both with count unchanged and FI staying 1.
REQ-020 SHALL give a latency of 1 clock from the dav_ low sample to FI=1 visible on STATUS.

Reset
REQ-021 SHALL, while reset_=0, asynchronously set state P_IDLE, rfd=1, FI=0, buffer count 0, RBR=8'h00, and the registered ior_ and iow_ to 1.
REQ-022 SHALL, when reset_ is asserted mid-handshake, discard captured data; after release, a still-low dav_ is treated as a new byte.

Configuration
REQ-023 SHALL, with IN_IFACE_FIFO2_EN defined, use a 2-entry FIFO: P_WAIT_HIGH returns to P_IDLE while count<2, so a second byte is accepted while the first awaits a read.
REQ-024 SHALL, without IN_IFACE_FIFO2_EN, use a single-entry buffer: after every capture, P_WAIT_HIGH goes to P_FULL until the RBR read.

Structure
REQ-025 SHALL place the shared package items (register offsets STATUS_OFS=0, RBR_OFS=1, CTRL_OFS=2; FI bit index 0; FSM state encoding) in the codebase's shared I/O package.
REQ-026 SHALL implement the buffer storage and count as one sub-module, in_iface_buf, with push, pop, flush, head and count.

Verification
REQ-027 SHALL verify basic: producer 8'h2A with dav_ low for 2 cycles -> rfd=0, STATUS reads 8'h01, RBR read returns 8'h2A, then STATUS reads 8'h00 and rfd=1.
REQ-028 SHALL verify back-to-back: 8'h11 then 8'h22 offered without reads -> with FIFO2 both accepted and read in order; without FIFO2 rfd stays 0 until the first RBR read.
REQ-029 SHALL verify empty read: RBR read with FI=0 after a prior 8'h55 -> returns 8'h55, FI stays 0, rfd stays 1.
REQ-030 SHALL verify flush: buffer holding 8'h7F, write 8'h01 to CTRL -> STATUS 8'h00, rfd=1.
REQ-031 SHALL verify reset mid-handshake: reset_ pulsed low during P_WAIT_HIGH -> rfd=1, FI=0, RBR=8'h00 immediately, without waiting for a clock.
REQ-032 SHALL verify collision: pop and capture in the same cycle (FIFO2, count=1) -> FI stays 1, next RBR read returns the new byte.
